alu_issue: RTL

Request-side sequencer for the integer `alu`. It accepts tagged operation requests from decode/test logic into a small FIFO and drives the ALU's `I_en`/`O_busy` handshake one operation at a time. It captures the ALU result and compare flags and returns them downstream on a valid/ready response port. It also bounds multi-cycle operations with a busy-timeout.

---
 rtl/alu_issue.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// Request sequencer for the integer ALU: queues tagged requests, issues them one at a
// time over the I_en/O_busy handshake, bounds busy time, and returns results downstream.
module alu_issue #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             I_clk,
    input  logic             I_reset,
    input  logic             I_req_valid,
    output logic             O_req_ready,
    input  logic [4:0]       I_req_op,
    input  logic [31:0]      I_req_a,
    input  logic [31:0]      I_req_b,
    input  logic [TAG_W-1:0] I_req_tag,
    output logic             O_alu_en,
    output logic [4:0]       O_alu_op,
    output logic [31:0]      O_alu_s1,
    output logic [31:0]      O_alu_s2,
    output logic             O_alu_kill,
    input  logic             I_alu_busy,
    input  logic [31:0]      I_alu_data,
    input  logic             I_alu_lt,
    input  logic             I_alu_ltu,
    input  logic             I_alu_eq,
    output logic             O_rsp_valid,
    input  logic             I_rsp_ready,
    output logic [31:0]      O_rsp_data,
    output logic [TAG_W-1:0] O_rsp_tag,
    output logic             O_rsp_lt,
    output logic             O_rsp_ltu,
    output logic             O_rsp_eq,
    output logic             O_rsp_err,
    output logic             O_idle
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    state_t state, next_state;

    logic [4:0]       op_mem  [DEPTH];
    logic [31:0]      a_mem   [DEPTH];
    logic [31:0]      b_mem   [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, empty, push, pop, timeout;
    logic [TO_W-1:0]  busy_cnt;

    logic [4:0]       hold_op;
    logic [31:0]      hold_a, hold_b, rsp_data;
    logic [TAG_W-1:0] hold_tag;
    logic             rsp_lt, rsp_ltu, rsp_eq, rsp_err, kill_q;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign push  = I_req_valid && !full;
    assign pop   = (state == S_IDLE) && !empty;

    always_ff @(posedge I_clk) begin
        if (push) begin
            op_mem[wr_ptr]  <= I_req_op;
            a_mem[wr_ptr]   <= I_req_a;
            b_mem[wr_ptr]   <= I_req_b;
            tag_mem[wr_ptr] <= I_req_tag;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally at their width.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) state <= S_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        timeout    = 1'b0;
        case (state)
            S_IDLE:  if (!empty) next_state = S_ISSUE;
            S_ISSUE: next_state = S_WAIT;
            S_WAIT: begin
                if (!I_alu_busy) begin
                    next_state = S_RESP;
                end else if (busy_cnt == TO_W'(TIMEOUT - 1)) begin
                    timeout    = 1'b1;
                    next_state = S_RESP;
                end
            end
            S_RESP:  if (I_rsp_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Hold registers change only on a pop, keeping ALU operands steady until the response drains.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            hold_op  <= '0;
            hold_a   <= '0;
            hold_b   <= '0;
            hold_tag <= '0;
            rsp_data <= '0;
            rsp_lt   <= 1'b0;
            rsp_ltu  <= 1'b0;
            rsp_eq   <= 1'b0;
            rsp_err  <= 1'b0;
            busy_cnt <= '0;
            kill_q   <= 1'b0;
        end else begin
            kill_q <= timeout;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        hold_op  <= op_mem[rd_ptr];
                        hold_a   <= a_mem[rd_ptr];
                        hold_b   <= b_mem[rd_ptr];
                        hold_tag <= tag_mem[rd_ptr];
                    end
                end
                S_ISSUE: busy_cnt <= '0;
                S_WAIT: begin
                    if (!I_alu_busy) begin
                        rsp_data <= I_alu_data;
                        rsp_lt   <= I_alu_lt;
                        rsp_ltu  <= I_alu_ltu;
                        rsp_eq   <= I_alu_eq;
                        rsp_err  <= 1'b0;
                    end else if (timeout) begin
                        rsp_data <= '0;
                        rsp_lt   <= 1'b0;
                        rsp_ltu  <= 1'b0;
                        rsp_eq   <= 1'b0;
                        rsp_err  <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign O_req_ready = !full;
    assign O_alu_en    = (state == S_ISSUE);
    assign O_alu_op    = hold_op;
    assign O_alu_s1    = hold_a;
    assign O_alu_s2    = hold_b;
    assign O_alu_kill  = kill_q;
    assign O_rsp_valid = (state == S_RESP);
    assign O_rsp_data  = rsp_data;
    assign O_rsp_tag   = hold_tag;
    assign O_rsp_lt    = rsp_lt;
    assign O_rsp_ltu   = rsp_ltu;
    assign O_rsp_eq    = rsp_eq;
    assign O_rsp_err   = rsp_err;
    assign O_idle      = empty && (state == S_IDLE);

endmodule
